// File: rtl/spi_platform_designer_spi_sequencer.sv
// Command sequencer for the 8-bit SPI master core. Runs one multi-byte
// transfer per command through the core's 3-bit register port: program the
// slave enable, hold SSO, exchange bytes via txdata/rxdata, release SSO.
module spi_platform_designer_spi_sequencer #(
  parameter int unsigned PollLimit = 1023
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  // Command handshake
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_len_i,
  input  logic [15:0] cmd_ss_i,
  // Transmit stream
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  // Receive stream
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  // Completion
  output logic        done_o,
  output logic        err_o,
  // SPI core register port
  output logic        spi_select_o,
  output logic        spi_read_n_o,
  output logic        spi_write_n_o,
  output logic [2:0]  spi_addr_o,
  output logic [15:0] spi_wdata_o,
  input  logic [15:0] spi_rdata_i
);

  localparam int unsigned PollW = 10;

  // Core register addresses
  localparam logic [2:0] AddrRx   = 3'd0;
  localparam logic [2:0] AddrTx   = 3'd1;
  localparam logic [2:0] AddrStat = 3'd2;
  localparam logic [2:0] AddrCtrl = 3'd3;
  localparam logic [2:0] AddrSs   = 3'd5;

  localparam logic [15:0] CtrlSso = 16'h0400;

  typedef enum logic [3:0] {
    StIdle,
    StWrSs,
    StWrSso,
    StPollTrdy,
    StWaitTx,
    StWrTx,
    StPollRrdy,
    StRdRx,
    StPushRx,
    StClrErr,
    StPollTmt,
    StWrRel,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;      // 0,1 = active cycles, 2 = re-arm gap
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [4:0]        remain_q, remain_d;
  logic [15:0]       ss_q, ss_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [3:0]        stat_q, stat_d;        // {E, RRDY, TRDY, TMT}
  logic              err_flag_q, err_flag_d;
  logic [7:0]        rx_data_q, rx_data_d;

  logic              cmd_ready_q, cmd_ready_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              sel_q, sel_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic [2:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              access_end;
  logic [PollW-1:0]  poll_next;
  logic              poll_expired;

  // Status bits above E and the low rxdata bits beyond the byte are ignored.
  logic unused_rdata;
  assign unused_rdata = ^spi_rdata_i[15:9];

  function automatic logic is_read(input state_e s);
    return s inside {StPollTrdy, StPollRrdy, StRdRx, StPollTmt};
  endfunction

  function automatic logic is_write(input state_e s);
    return s inside {StWrSs, StWrSso, StWrTx, StClrErr, StWrRel};
  endfunction

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      phase_q    <= 2'd0;
      poll_cnt_q <= '0;
      remain_q   <= 5'd0;
      ss_q       <= 16'h0000;
      tx_byte_q  <= 8'h00;
      stat_q     <= 4'h0;
      err_flag_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      remain_q   <= remain_d;
      ss_q       <= ss_d;
      tx_byte_q  <= tx_byte_d;
      stat_q     <= stat_d;
      err_flag_q <= err_flag_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Next-state: access phasing, poll accounting and command sequencing
  always_comb begin
    state_d    = state_q;
    phase_d    = 2'd0;
    poll_cnt_d = poll_cnt_q;
    remain_d   = remain_q;
    ss_d       = ss_q;
    tx_byte_d  = tx_byte_q;
    stat_d     = stat_q;
    err_flag_d = err_flag_q;
    rx_data_d  = rx_data_q;

    access_end   = (phase_q == 2'd2);
    poll_next    = poll_cnt_q + 10'd1;
    poll_expired = (poll_next == PollW'(PollLimit));

    if (is_read(state_q) || is_write(state_q)) begin
      phase_d = access_end ? 2'd0 : phase_q + 2'd1;
    end

    // Read data is taken at the end of the second active cycle.
    if (is_read(state_q) && phase_q == 2'd1) begin
      stat_d = spi_rdata_i[8:5];
      if (state_q == StRdRx) begin
        rx_data_d = spi_rdata_i[7:0];
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          remain_d   = (cmd_len_i == 4'd0) ? 5'd16 : {1'b0, cmd_len_i};
          ss_d       = cmd_ss_i;
          err_flag_d = 1'b0;
          state_d    = StWrSs;
        end
      end
      StWrSs: if (access_end) state_d = StWrSso;
      StWrSso: begin
        if (access_end) begin
          state_d    = StPollTrdy;
          poll_cnt_d = '0;
        end
      end
      StPollTrdy: begin
        if (access_end) begin
          if (stat_q[1]) begin
            state_d = StWaitTx;
          end else if (poll_expired) begin
            err_flag_d = 1'b1;
            state_d    = StWrRel;
          end else begin
            poll_cnt_d = poll_next;
          end
        end
      end
      StWaitTx: begin
        if (tx_valid_i && tx_ready_q) begin
          tx_byte_d = tx_data_i;
          state_d   = StWrTx;
        end
      end
      StWrTx: begin
        if (access_end) begin
          state_d    = StPollRrdy;
          poll_cnt_d = '0;
        end
      end
      StPollRrdy: begin
        if (access_end) begin
          if (stat_q[2]) begin
            // Overrun is cleared before the byte is fetched.
            state_d = stat_q[3] ? StClrErr : StRdRx;
          end else if (poll_expired) begin
            err_flag_d = 1'b1;
            state_d    = StWrRel;
          end else begin
            poll_cnt_d = poll_next;
          end
        end
      end
      StClrErr: begin
        if (access_end) begin
          err_flag_d = 1'b1;
          state_d    = StRdRx;
        end
      end
      StRdRx: if (access_end) state_d = StPushRx;
      StPushRx: begin
        if (rx_ready_i) begin
          remain_d   = remain_q - 5'd1;
          poll_cnt_d = '0;
          state_d    = (remain_q == 5'd1) ? StPollTmt : StPollTrdy;
        end
      end
      StPollTmt: begin
        if (access_end) begin
          if (stat_q[0]) begin
            state_d = StWrRel;
          end else if (poll_expired) begin
            err_flag_d = 1'b1;
            state_d    = StWrRel;
          end else begin
            poll_cnt_d = poll_next;
          end
        end
      end
      StWrRel: if (access_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: decoded from the upcoming state so they can be registered
  always_comb begin
    cmd_ready_d = (state_d == StIdle);
    tx_ready_d  = (state_d == StWaitTx);
    rx_valid_d  = (state_d == StPushRx);
    done_d      = (state_d == StDone);
    err_d       = (state_d == StDone) && err_flag_d;

    sel_d   = (is_read(state_d) || is_write(state_d)) && (phase_d != 2'd2);
    rd_n_d  = !(sel_d && is_read(state_d));
    wr_n_d  = !(sel_d && is_write(state_d));
    addr_d  = 3'd0;
    wdata_d = 16'h0000;

    if (sel_d) begin
      unique case (state_d)
        StWrSs:     begin addr_d = AddrSs;   wdata_d = ss_d;                end
        StWrSso:    begin addr_d = AddrCtrl; wdata_d = CtrlSso;             end
        StWrTx:     begin addr_d = AddrTx;   wdata_d = {8'h00, tx_byte_d};  end
        StClrErr:   begin addr_d = AddrStat; wdata_d = 16'h0000;            end
        StWrRel:    begin addr_d = AddrCtrl; wdata_d = 16'h0000;            end
        StRdRx:     addr_d = AddrRx;
        StPollTrdy,
        StPollRrdy,
        StPollTmt:  addr_d = AddrStat;
        default:    addr_d = 3'd0;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cmd_ready_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sel_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      addr_q      <= 3'd0;
      wdata_q     <= 16'h0000;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sel_q       <= sel_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign spi_select_o  = sel_q;
  assign spi_read_n_o  = rd_n_q;
  assign spi_write_n_o = wr_n_q;
  assign spi_addr_o    = addr_q;
  assign spi_wdata_o   = wdata_q;

endmodule

// File: tb/tb_spi_platform_designer_spi_sequencer.sv
// Bench for the SPI sequencer: a small core model loops MOSI to MISO,
// write accesses and received bytes are checked against scoreboard queues.
module tb_spi_platform_designer_spi_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_ss;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        done, err;
  logic        spi_select, spi_read_n, spi_write_n;
  logic [2:0]  spi_addr;
  logic [15:0] spi_wdata, spi_rdata;

  always #5 clk = ~clk;

  spi_platform_designer_spi_sequencer #(
    .PollLimit(8)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_len_i    (cmd_len),
    .cmd_ss_i     (cmd_ss),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .done_o       (done),
    .err_o        (err),
    .spi_select_o (spi_select),
    .spi_read_n_o (spi_read_n),
    .spi_write_n_o(spi_write_n),
    .spi_addr_o   (spi_addr),
    .spi_wdata_o  (spi_wdata),
    .spi_rdata_i  (spi_rdata)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [3:0]  len;
    logic [15:0] ss;
    logic [7:0]  base;
    bit          overrun;
    bit          never;
    int          stall_beat;
    int          stall_len;
    bit          exp_err;
  } vec_t;

  int n_cmp  = 0;
  int n_miss = 0;

  wr_t        exp_wr[$];
  logic [7:0] exp_rx[$];

  // Core model state
  bit         overrun_mode = 1'b0;
  bit         never_mode   = 1'b0;
  bit         m_tx_pend    = 1'b0;
  bit         m_rrdy       = 1'b0;
  int         m_pend_cnt   = 0;
  logic [7:0] m_tx_byte    = 8'h00;
  logic [7:0] m_rx_byte    = 8'h00;
  int         stat_reads   = 0;
  int         rel_reads    = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx_pend  = 1'b0;
    m_rrdy     = 1'b0;
    m_pend_cnt = 0;
    m_tx_byte  = 8'h00;
    m_rx_byte  = 8'h00;
    stat_reads = 0;
    rel_reads  = -1;
  endtask

  // Core register read data: rxdata and status
  always_comb begin
    spi_rdata = 16'h0000;
    if (spi_addr == 3'd0) begin
      spi_rdata = {8'h00, m_rx_byte};
    end else if (spi_addr == 3'd2) begin
      spi_rdata = {7'b0, m_rrdy & overrun_mode, m_rrdy, !m_tx_pend, !m_tx_pend, 5'b0};
    end
  end

  // Access monitor: protocol checks, write scoreboard and core side effects
  int          sel_cnt = 0;
  logic [2:0]  acc_addr;
  logic [15:0] acc_wdata;
  bit          acc_rd, acc_wr;

  always @(negedge clk) begin
    if (!reset_n) begin
      sel_cnt = 0;
    end else if (spi_select) begin
      sel_cnt++;
      if (sel_cnt == 1) begin
        acc_addr  = spi_addr;
        acc_wdata = spi_wdata;
        acc_rd    = !spi_read_n;
        acc_wr    = !spi_write_n;
      end else if (sel_cnt == 2) begin
        chk("access held", {spi_addr, spi_wdata, !spi_read_n, !spi_write_n},
            {acc_addr, acc_wdata, acc_rd, acc_wr});
        chk("single strobe", acc_rd ^ acc_wr, 1);
      end
    end else if (sel_cnt != 0) begin
      chk("access length", sel_cnt, 2);
      chk("idle strobes", {spi_read_n, spi_write_n}, 2'b11);
      sel_cnt = 0;
      if (acc_wr) begin
        if (acc_addr == 3'd1) begin
          m_tx_pend  = 1'b1;
          m_tx_byte  = acc_wdata[7:0];
          m_pend_cnt = 0;
          stat_reads = 0;
        end
        if (acc_addr == 3'd3 && acc_wdata == 16'h0000) rel_reads = stat_reads;
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_miss++;
          $display("FAIL unexpected write: got addr %0d data 0x%0h, want none", acc_addr,
                   acc_wdata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write addr/data", {acc_addr, acc_wdata}, {e.addr, e.data});
        end
      end else if (acc_rd) begin
        if (acc_addr == 3'd2) begin
          stat_reads++;
          if (m_tx_pend && !never_mode) begin
            m_pend_cnt++;
            if (m_pend_cnt == 2) begin
              m_rrdy    = 1'b1;
              m_tx_pend = 1'b0;
              m_rx_byte = m_tx_byte;
            end
          end
        end else if (acc_addr == 3'd0) begin
          m_rrdy = 1'b0;
        end
      end
    end
  end

  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 0);
    chk({tag, " tx_ready"}, tx_ready, 0);
    chk({tag, " rx_valid"}, rx_valid, 0);
    chk({tag, " rx_data"}, rx_data, 0);
    chk({tag, " done/err"}, {done, err}, 0);
    chk({tag, " spi strobes"}, {spi_select, spi_read_n, spi_write_n}, 3'b011);
    chk({tag, " spi addr/wdata"}, {spi_addr, spi_wdata}, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  n, n_tx_exp, n_rx_exp, tx_idx, beats, stall;
    bit  accepted, got_done, got_err;
    n        = (v.len == 4'd0) ? 16 : int'(v.len);
    n_tx_exp = v.never ? 1 : n;
    n_rx_exp = v.never ? 0 : n;
    tx_idx   = 0;
    beats    = 0;
    stall    = 0;
    accepted = 0;
    got_done = 0;
    got_err  = 0;
    model_reset();
    overrun_mode = v.overrun;
    never_mode   = v.never;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = v.len;
    cmd_ss    = v.ss;
    tx_valid  = 1'b1;
    tx_data   = v.base;
    rx_ready  = !(v.stall_beat == 0 && v.stall_len > 0);
    for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
        accepted = 1;
        push_wr(3'd5, v.ss);
        push_wr(3'd3, 16'h0400);
      end
      if (tx_valid && tx_ready) begin
        push_wr(3'd1, {8'h00, tx_data});
        if (v.overrun) push_wr(3'd2, 16'h0000);
        if (v.never) push_wr(3'd3, 16'h0000);
        else exp_rx.push_back(tx_data);
        tx_idx++;
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_cmp++;
          n_miss++;
          $display("FAIL %s rx beat: got 0x%0h, want no beat", tag, rx_data);
        end else if (rx_ready) begin
          chk({tag, " rx byte"}, rx_data, exp_rx.pop_front());
          beats++;
          if (beats == n) push_wr(3'd3, 16'h0000);
        end else begin
          chk({tag, " rx hold"}, rx_data, exp_rx[0]);
          stall++;
        end
      end
      if (done) begin
        got_done = 1;
        got_err  = err;
      end
      @(posedge clk);
      #1;
      cmd_valid = !accepted;
      tx_valid  = (tx_idx < n);
      tx_data   = v.base + 8'(tx_idx);
      rx_ready  = !(beats == v.stall_beat && stall < v.stall_len);
    end
    cmd_valid = 1'b0;
    tx_valid  = 1'b0;
    rx_ready  = 1'b1;
    if (!got_done) begin
      n_cmp++;
      n_miss++;
      $display("FAIL %s done: got no done within budget, want done", tag);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      reset_n = 1'b1;
    end else begin
      chk({tag, " err"}, got_err, v.exp_err);
      @(negedge clk);
      chk({tag, " done pulse"}, done, 0);
      chk({tag, " tx beats"}, tx_idx, n_tx_exp);
      chk({tag, " rx beats"}, beats, n_rx_exp);
      chk({tag, " writes left"}, exp_wr.size(), 0);
      if (v.never) chk({tag, " status reads"}, rel_reads, 8);
    end
    exp_wr.delete();
    exp_rx.delete();
  endtask

  vec_t vecs[6];
  vec_t post;

  initial begin
    vecs[0] = '{4'd1, 16'h0001, 8'hA5, 1'b0, 1'b0, -1, 0,   1'b0};  // single byte
    vecs[1] = '{4'd0, 16'h0002, 8'h00, 1'b0, 1'b0, -1, 0,   1'b0};  // 16 bytes
    vecs[2] = '{4'd3, 16'h0004, 8'h30, 1'b0, 1'b0, 1,  500, 1'b0};  // rx back-pressure
    vecs[3] = '{4'd2, 16'h8000, 8'hC0, 1'b1, 1'b0, -1, 0,   1'b1};  // overrun
    vecs[4] = '{4'd2, 16'h0010, 8'h50, 1'b0, 1'b1, -1, 0,   1'b1};  // RRDY timeout
    vecs[5] = '{4'd5, 16'h00FF, 8'h10, 1'b0, 1'b0, 0,  3,   1'b0};  // short stall, first beat
    post    = '{4'd1, 16'h0040, 8'h3C, 1'b0, 1'b0, -1, 0,   1'b0};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = 4'd0;
    cmd_ss    = 16'h0000;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset while waiting for a tx byte
    begin
      bit accepted;
      bit reached;
      accepted = 0;
      reached  = 0;
      model_reset();
      overrun_mode = 1'b0;
      never_mode   = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_len   = 4'd2;
      cmd_ss    = 16'h0003;
      for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
        @(negedge clk);
        if (cmd_valid && cmd_ready) begin
          accepted = 1;
          push_wr(3'd5, 16'h0003);
          push_wr(3'd3, 16'h0400);
        end
        if (tx_ready) begin
          reached = 1;
        end else begin
          @(posedge clk);
          #1;
          cmd_valid = !accepted;
        end
      end
      chk("reached WAIT_TX", reached, 1);
      chk("setup writes", exp_wr.size(), 0);
      #2;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      #1;
      chk_reset_outputs("async");
      repeat (3) @(posedge clk);
      exp_wr.delete();
      exp_rx.delete();
      @(negedge clk);
      reset_n = 1'b1;
      run_vec(post, "post-reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
